// File: rtl/wb_queue.sv
// In-order write-back queue feeding the single register-file write port.
// Two producers enqueue (B ahead of A). One entry drains per cycle. Queries report pending writes.
module wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          aValid,
  output logic          aReady,
  input  logic [4:0]    aReg,
  input  logic [31:0]   aData,

  input  logic          bValid,
  output logic          bReady,
  input  logic [4:0]    bReg,
  input  logic [31:0]   bData,

  output logic          RegWre,
  output logic [4:0]    writeReg,
  output logic [31:0]   writeData,

  input  logic [4:0]    qReg1,
  input  logic [4:0]    qReg2,
  output logic          busy1,
  output logic          busy2,
  output logic [31:0]   fwd1,
  output logic [31:0]   fwd2,

  output logic [AW:0]   count
);

  localparam logic [AW+1:0] DepthW = (AW+2)'(DEPTH);
  localparam logic [AW+1:0] OneW   = (AW+2)'(1);
  localparam logic [AW+1:0] TwoW   = (AW+2)'(2);

  logic [4:0]    regMem  [DEPTH];
  logic [31:0]   dataMem [DEPTH];

  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] aSlot;
  logic [AW-1:0] idx;
  logic [AW:0]   enqCnt;
  logic [AW:0]   countNext;
  logic [AW+1:0] free;
  logic          nonEmpty;
  logic          aNeed;
  logic          bNeed;
  logic          aEnq;
  logic          bEnq;

  assign nonEmpty = (count != '0);

  // The head leaves at this edge, so its slot is reusable by an incoming write.
  assign free = DepthW - {1'b0, count} + (AW+2)'(nonEmpty);

  assign aNeed = (aReg != 5'd0);
  assign bNeed = (bReg != 5'd0);

  // Register-zero writes are accepted without taking a slot.
  assign bReady = rst_n && bValid && (!bNeed || (free >= OneW));
  assign aReady = rst_n && aValid &&
                  (!aNeed || (free >= ((bValid && bNeed) ? TwoW : OneW)));

  assign bEnq = bReady && bNeed;
  assign aEnq = aReady && aNeed;

  assign enqCnt    = (AW+1)'(aEnq) + (AW+1)'(bEnq);
  assign countNext = count + enqCnt - (AW+1)'(nonEmpty);

  // B is the older instruction, so it takes the first slot when both enqueue.
  assign aSlot = wrPtr + AW'(bEnq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      count <= countNext;
      wrPtr <= wrPtr + enqCnt[AW-1:0];
      if (nonEmpty) begin
        rdPtr <= rdPtr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bEnq) begin
      regMem[wrPtr]  <= bReg;
      dataMem[wrPtr] <= bData;
    end
    if (aEnq) begin
      regMem[aSlot]  <= aReg;
      dataMem[aSlot] <= aData;
    end
  end

  always_comb begin
    RegWre    = nonEmpty;
    writeReg  = 5'd0;
    writeData = 32'd0;
    if (nonEmpty) begin
      writeReg  = regMem[rdPtr];
      writeData = dataMem[rdPtr];
    end
  end

  // Scan oldest to youngest; later matches overwrite, leaving the youngest data.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    fwd1  = 32'd0;
    fwd2  = 32'd0;
    idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rdPtr + AW'(i);
      if (i < 32'(count)) begin
        if ((qReg1 != 5'd0) && (regMem[idx] == qReg1)) begin
          busy1 = 1'b1;
          fwd1  = dataMem[idx];
        end
        if ((qReg2 != 5'd0) && (regMem[idx] == qReg2)) begin
          busy2 = 1'b1;
          fwd2  = dataMem[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: scoreboard on the drain port plus per-scenario checks.
module tb_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk;
  logic          rst_n;
  logic          aValid;
  logic          aReady;
  logic [4:0]    aReg;
  logic [31:0]   aData;
  logic          bValid;
  logic          bReady;
  logic [4:0]    bReg;
  logic [31:0]   bData;
  logic          RegWre;
  logic [4:0]    writeReg;
  logic [31:0]   writeData;
  logic [4:0]    qReg1;
  logic [4:0]    qReg2;
  logic          busy1;
  logic          busy2;
  logic [31:0]   fwd1;
  logic [31:0]   fwd2;
  logic [AW:0]   count;

  int checks;
  int passes;
  logic [36:0] sb [$];

  wb_queue #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .aValid   (aValid),
    .aReady   (aReady),
    .aReg     (aReg),
    .aData    (aData),
    .bValid   (bValid),
    .bReady   (bReady),
    .bReg     (bReg),
    .bData    (bData),
    .RegWre   (RegWre),
    .writeReg (writeReg),
    .writeData(writeData),
    .qReg1    (qReg1),
    .qReg2    (qReg2),
    .busy1    (busy1),
    .busy2    (busy2),
    .fwd1     (fwd1),
    .fwd2     (fwd2),
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drain scoreboard: compare the head first, then record what the next edge accepts.
  always @(negedge clk) begin
    logic [36:0] exp;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (RegWre) begin
        checks++;
        if (sb.size() == 0) begin
          $display("FAIL drain_unexpected got reg=%0d data=%h want no write", writeReg, writeData);
        end else begin
          exp = sb.pop_front();
          if ({writeReg, writeData} !== exp)
            $display("FAIL drain_order got reg=%0d data=%h want reg=%0d data=%h",
                     writeReg, writeData, exp[36:32], exp[31:0]);
          else
            passes++;
        end
      end
      if (bValid && bReady && (bReg != 5'd0)) sb.push_back({bReg, bData});
      if (aValid && aReady && (aReg != 5'd0)) sb.push_back({aReg, aData});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    aValid = 1'b0; aReg = 5'd0; aData = 32'd0;
    bValid = 1'b0; bReg = 5'd0; bData = 32'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    qReg1 = 5'd6;
    qReg2 = 5'd0;
    repeat (2) tick();
    aValid = 1'b1; aReg = 5'd6; aData = 32'h66;
    bValid = 1'b1; bReg = 5'd2; bData = 32'h22;
    @(negedge clk);
    checks++; if (aReady !== 1'b0) $display("FAIL reset_aReady got %b want 0", aReady); else passes++;
    checks++; if (bReady !== 1'b0) $display("FAIL reset_bReady got %b want 0", bReady); else passes++;
    checks++; if (count !== 3'd0) $display("FAIL reset_count got %0d want 0", count); else passes++;
    checks++; if (RegWre !== 1'b0) $display("FAIL reset_RegWre got %b want 0", RegWre); else passes++;
    checks++;
    if ({writeReg, writeData} !== 37'd0)
      $display("FAIL reset_write got %0d/%h want 0/0", writeReg, writeData);
    else passes++;
    checks++;
    if ({busy1, fwd1} !== 33'd0) $display("FAIL reset_query got %b/%h want 0/0", busy1, fwd1);
    else passes++;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_single();
    qReg1 = 5'd5;
    aValid = 1'b1; aReg = 5'd5; aData = 32'h1234;
    @(negedge clk);
    checks++; if (aReady !== 1'b1) $display("FAIL single_aReady got %b want 1", aReady); else passes++;
    checks++; if (busy1 !== 1'b0) $display("FAIL single_busy_pre got %b want 0", busy1); else passes++;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (RegWre !== 1'b1) $display("FAIL single_RegWre got %b want 1", RegWre); else passes++;
    checks++;
    if ({writeReg, writeData} !== {5'd5, 32'h1234})
      $display("FAIL single_write got %0d/%h want 5/1234", writeReg, writeData);
    else passes++;
    checks++;
    if ({busy1, fwd1} !== {1'b1, 32'h1234})
      $display("FAIL single_query got %b/%h want 1/1234", busy1, fwd1);
    else passes++;
    tick();
    @(negedge clk);
    checks++; if (RegWre !== 1'b0) $display("FAIL single_idle got %b want 0", RegWre); else passes++;
    checks++; if (count !== 3'd0) $display("FAIL single_count got %0d want 0", count); else passes++;
    tick();
  endtask

  task automatic test_dual();
    qReg1 = 5'd3;
    aValid = 1'b1; aReg = 5'd3; aData = 32'hA;
    bValid = 1'b1; bReg = 5'd3; bData = 32'hB;
    @(negedge clk);
    checks++;
    if ({aReady, bReady} !== 2'b11) $display("FAIL dual_ready got %b want 11", {aReady, bReady});
    else passes++;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({writeReg, writeData} !== {5'd3, 32'hB})
      $display("FAIL dual_first got %0d/%h want 3/b", writeReg, writeData);
    else passes++;
    checks++; if (count !== 3'd2) $display("FAIL dual_count got %0d want 2", count); else passes++;
    checks++; if (fwd1 !== 32'hA) $display("FAIL dual_fwd got %h want a", fwd1); else passes++;
    tick();
    @(negedge clk);
    checks++; if (writeData !== 32'hA) $display("FAIL dual_second got %h want a", writeData); else passes++;
    tick();
  endtask

  task automatic test_fill();
    int mc;
    int fr;
    logic expA;
    logic bN;
    mc = 0;
    for (int k = 0; k < 10; k++) begin
      bValid = 1'b1; bReg = (k == 7) ? 5'd0 : 5'(1 + k % 6); bData = 32'hB00 + 32'(k);
      aValid = 1'b1; aReg = 5'(10 + k % 6); aData = 32'hA00 + 32'(k);
      @(negedge clk);
      fr   = int'(DEPTH) - mc + ((mc > 0) ? 1 : 0);
      bN   = (bReg != 5'd0);
      expA = (fr >= (bN ? 2 : 1));
      checks++;
      if (count !== 3'(mc)) $display("FAIL fill_count k=%0d got %0d want %0d", k, count, mc);
      else passes++;
      checks++;
      if (aReady !== expA) $display("FAIL fill_aReady k=%0d got %b want %b", k, aReady, expA);
      else passes++;
      checks++;
      if (bReady !== 1'b1) $display("FAIL fill_bReady k=%0d got %b want 1", k, bReady);
      else passes++;
      mc = mc + (bN ? 1 : 0) + (expA ? 1 : 0) - ((mc > 0) ? 1 : 0);
      tick();
    end
    idle_inputs();
    repeat (DEPTH + 1) tick();
    @(negedge clk);
    checks++; if (count !== 3'd0) $display("FAIL fill_drained got %0d want 0", count); else passes++;
    tick();
  endtask

  task automatic test_zero();
    qReg1 = 5'd0;
    aValid = 1'b1; aReg = 5'd0; aData = 32'hFFFF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (aReady !== 1'b1) $display("FAIL zero_aReady got %b want 1", aReady); else passes++;
      checks++; if (count !== 3'd0) $display("FAIL zero_count got %0d want 0", count); else passes++;
      checks++; if (RegWre !== 1'b0) $display("FAIL zero_RegWre got %b want 0", RegWre); else passes++;
      checks++; if (busy1 !== 1'b0) $display("FAIL zero_busy got %b want 0", busy1); else passes++;
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_fwd_youngest();
    logic        expBusy [4];
    logic [31:0] expFwd  [4];
    expBusy = '{1'b0, 1'b1, 1'b1, 1'b1};
    expFwd  = '{32'h0, 32'h11, 32'h33, 32'h33};
    qReg2 = 5'd7;
    bValid = 1'b1; bReg = 5'd7; bData = 32'h11;
    aValid = 1'b1; aReg = 5'd9; aData = 32'h22;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if ({busy2, fwd2} !== {expBusy[k], expFwd[k]})
        $display("FAIL fwd_step%0d got %b/%h want %b/%h", k, busy2, fwd2, expBusy[k], expFwd[k]);
      else passes++;
      tick();
      idle_inputs();
      if (k == 0) begin
        aValid = 1'b1; aReg = 5'd7; aData = 32'h33;
      end
    end
    @(negedge clk);
    checks++;
    if ({busy2, fwd2} !== 33'd0) $display("FAIL fwd_drop got %b/%h want 0/0", busy2, fwd2);
    else passes++;
    qReg2 = 5'd0;
    tick();
  endtask

  task automatic test_reset_mid();
    qReg1 = 5'd3;
    bValid = 1'b1; bReg = 5'd1; bData = 32'h101;
    aValid = 1'b1; aReg = 5'd2; aData = 32'h102;
    tick();
    bReg = 5'd3; bData = 32'h103;
    aReg = 5'd4; aData = 32'h104;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (count !== 3'd3) $display("FAIL mid_prefill got %0d want 3", count); else passes++;
    tick();
    rst_n = 1'b0;
    aValid = 1'b1; aReg = 5'd6; aData = 32'h66;
    @(negedge clk);
    checks++; if (aReady !== 1'b0) $display("FAIL mid_aReady got %b want 0", aReady); else passes++;
    tick();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    checks++; if (count !== 3'd0) $display("FAIL mid_count got %0d want 0", count); else passes++;
    checks++; if (RegWre !== 1'b0) $display("FAIL mid_RegWre got %b want 0", RegWre); else passes++;
    checks++; if (busy1 !== 1'b0) $display("FAIL mid_busy got %b want 0", busy1); else passes++;
    tick();
    aValid = 1'b1; aReg = 5'd4; aData = 32'h5;
    @(negedge clk);
    checks++; if (aReady !== 1'b1) $display("FAIL mid_after_ready got %b want 1", aReady); else passes++;
    checks++; if (RegWre !== 1'b0) $display("FAIL mid_no_pass got %b want 0", RegWre); else passes++;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++;
    if ({RegWre, writeReg, writeData} !== {1'b1, 5'd4, 32'h5})
      $display("FAIL mid_after_write got %b/%0d/%h want 1/4/5", RegWre, writeReg, writeData);
    else passes++;
    tick();
    tick();
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_single();
    test_dual();
    test_fill();
    test_zero();
    test_fwd_youngest();
    test_reset_mid();
    @(negedge clk);
    checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover got %0d want 0", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_queue.md
Name: wb_queue

Overview:
- Write-back queue between the producers and the register file's single write port (rd/writeData/RegWre).
- Port A (ALU results) and port B (data-memory / long-latency results) enqueue register writes into an in-order FIFO.
- The FIFO drains one write per cycle to the register file.
- Read-side query ports report whether a register has a pending write and forward the youngest pending data, so decode can stall or bypass.

Parameters:
- DEPTH, 4, FIFO entries. Power of two, at least 2.
- AW, 2, pointer width, log2(DEPTH).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- aValid  in  1  port A write request
- aReady  out  1  port A accepted this cycle
- aReg  in  5  port A destination register
- aData  in  32  port A write data
- bValid  in  1  port B write request
- bReady  out  1  port B accepted this cycle
- bReg  in  5  port B destination register
- bData  in  32  port B write data
- RegWre  out  1  register-file write enable
- writeReg  out  5  register-file write address
- writeData  out  32  register-file write data
- qReg1  in  5  query register 1 (rs)
- qReg2  in  5  query register 2 (rt)
- busy1  out  1  qReg1 has a pending write
- busy2  out  1  qReg2 has a pending write
- fwd1  out  32  youngest pending data for qReg1, 0 if not busy
- fwd2  out  32  youngest pending data for qReg2, 0 if not busy
- count  out  AW+1  valid entries in the FIFO

Behaviour:
- Storage: circular FIFO with wrPtr, rdPtr, count. Each entry holds reg[4:0] and data[31:0].
- Drain: while count>0, RegWre=1 and writeReg/writeData come combinationally from the head entry. The head is dequeued at every clock edge with count>0; the register file always accepts.
- Free slots this cycle: free = DEPTH - count + (count>0 ? 1 : 0).
- bReady = bValid && free>=1.
- aReady = aValid && (free >= (bValid ? 2 : 1)).
- Port B has priority. When both ports are accepted in the same cycle, B is enqueued ahead of A (B is the older instruction).
- A request with reg==0 is accepted under the same ready rule but not enqueued. No slot is consumed, and such a request alone does not need a free slot: aReady=aValid when aReg==0.
- The same applies to B: bReady=bValid when bReg==0. A zero-register request on one port does not reduce the slots seen by the other port.
- Latency: an entry enqueued at edge n appears on RegWre/writeReg/writeData in the cycle after n. There is no same-cycle pass-through.
- Count update: count_next = count + enq_count - (count>0). Pointers wrap modulo DEPTH.
- Full (count==DEPTH): free=1. Exactly one enqueue is possible; it is simultaneous with the dequeue.
- Empty (count==0): RegWre=0, writeReg=0, writeData=0.
- Query: busyN=1 iff some valid entry has reg==qRegN and qRegN!=0.
  - fwdN = data of the youngest matching entry (closest to wrPtr).
  - The head entry being written this cycle counts as pending.
  - Queries see FIFO contents only, not same-cycle incoming requests.
- Ordering: entries for the same register drain oldest-first, so the register file ends with the youngest value.
- Reset: when rst_n=0 at an edge, all of the following clear:
  - count=0, wrPtr=0, rdPtr=0
  - RegWre=0, writeReg=0, writeData=0
  - busy=0, fwd=0
- Reset mid-operation discards pending writes and ignores requests in that cycle. While rst_n=0, aReady=0 and bReady=0.
- All outputs are well defined with X-free defaults. Entry contents need no reset, but valid tracking derives from count and pointers only.

Test Plan:
- Reset then single write: aValid, aReg=5, aData=0x1234 for one cycle -> aReady=1.
  - Next cycle: RegWre=1, writeReg=5, writeData=0x1234, busy1=1 with qReg1=5.
  - Following cycle: RegWre=0, count=0.
- Dual enqueue ordering: empty queue; same cycle aReg=3/0xA, bReg=3/0xB.
  - Next cycle: writeReg=3, writeData=0xB, count=2, fwd1=0xA (qReg1=3).
  - Then writeData=0xA.
- Fill/backpressure: hold bValid with distinct regs 1..6 and aValid continuously.
  - count saturates at DEPTH.
  - At full, bReady=1 and aReady=0 each cycle; one write drains per cycle.
  - No entry is lost or reordered.
- Register zero: aReg=0, aData=0xFFFF -> aReady=1, count stays 0, RegWre never asserted.
  - qReg1=0 gives busy1=0 throughout.
- Forwarding youngest: enqueue reg7=0x11, reg9=0x22, reg7=0x33 on consecutive cycles.
  - With qReg2=7 during drain: fwd2=0x33 until the last reg7 entry drains; busy2 drops the cycle after it writes.
- Mid-operation reset: queue holding 3 entries, rst_n=0 for one edge.
  - Next cycle: count=0, RegWre=0, busy=0.
  - A subsequent aReg=4/0x5 write appears one cycle after acceptance.
